// File: rtl/wr_burst_reader_pkg.sv
// wr_burst_reader_pkg: shared state encoding and counter sizing for the burst reader
package wr_burst_reader_pkg;
  typedef enum logic [1:0] {IDLE, REQ, READ} state_t;
  function automatic int burst_cnt_width(input int burst);
    return $clog2(burst + 1);
  endfunction
endpackage

// File: rtl/wr_burst_reader.sv
// wr_burst_reader: pops full write bursts from the data FIFO and streams them to the DDR2 controller
module wr_burst_reader
  import wr_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int WRITE_BURST = 8,
  parameter int ADDR_WIDTH  = 25,
  parameter int ADDR_LIMIT  = 2 ** ADDR_WIDTH
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [9:0]            rd_data_count,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_dout_vd,
  output logic                  rd_fifo,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_ack,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_vd,
  output logic                  busy,
  output logic                  burst_done,
  output logic                  err
);
  localparam int CW = burst_cnt_width(WRITE_BURST);
  localparam logic [9:0] THRESH = 10'(WRITE_BURST);
  localparam logic [CW-1:0] LAST_POP = CW'(WRITE_BURST - 1);
  localparam logic [CW-1:0] FULL = CW'(WRITE_BURST);
  localparam logic [ADDR_WIDTH:0] STEP = (ADDR_WIDTH + 1)'(WRITE_BURST);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(ADDR_LIMIT);
  state_t state;
  logic [CW-1:0] pop_cnt;
  logic [CW-1:0] beat_cnt;
  logic [ADDR_WIDTH:0] addr_sum;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic extra_beat;
  assign busy = state != IDLE;
  // next burst start address, wrapping to zero at the limit
  always_comb begin
    addr_sum  = {1'b0, wr_addr} + STEP;
    next_addr = addr_sum >= LIMIT ? '0 : addr_sum[ADDR_WIDTH-1:0];
  end
  assign extra_beat = fifo_dout_vd && beat_cnt == FULL;
  // burst FSM: request slot, pop the burst, forward the returned words, advance address
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rd_fifo    <= 1'b0;
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_data_vd <= 1'b0;
      burst_done <= 1'b0;
      err        <= 1'b0;
      pop_cnt    <= '0;
      beat_cnt   <= '0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          wr_data_vd <= 1'b0;
          if (fifo_dout_vd) err <= 1'b1;
          if (enable && rd_data_count >= THRESH) begin
            state  <= REQ;
            wr_req <= 1'b1;
          end
        end
        REQ: begin
          wr_data_vd <= 1'b0;
          if (fifo_dout_vd) err <= 1'b1;
          if (wr_ack) begin
            wr_req   <= 1'b0;
            rd_fifo  <= 1'b1;
            pop_cnt  <= '0;
            beat_cnt <= '0;
            state    <= READ;
          end
        end
        READ: begin
          if (rd_fifo) begin
            pop_cnt <= pop_cnt + CW'(1);
            if (pop_cnt == LAST_POP) rd_fifo <= 1'b0;
          end
          if (fifo_dout_vd && !extra_beat) begin
            wr_data    <= fifo_dout;
            wr_data_vd <= 1'b1;
            beat_cnt   <= beat_cnt + CW'(1);
          end else begin
            wr_data_vd <= 1'b0;
          end
          if (extra_beat) err <= 1'b1;
          if (beat_cnt == FULL) begin
            burst_done <= 1'b1;
            wr_addr    <= next_addr;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wr_burst_reader.sv
// tb_wr_burst_reader: directed checks of thresholding, burst timing, wrap, enable drop, reset and err
module tb_wr_burst_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [9:0] rd_data_count = '0;
  logic [63:0] fifo_dout = '0;
  logic fifo_dout_vd = 1'b0;
  logic rd_fifo, wr_req, wr_data_vd, busy, burst_done, err;
  logic [24:0] wr_addr;
  logic wr_ack = 1'b0;
  logic [63:0] wr_data;
  logic popped;
  logic [63:0] q[$];
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [63:0] base;
    logic [24:0] addr;
  } vec_t;
  vec_t vecs[5];

  wr_burst_reader #(.DATA_WIDTH(64), .WRITE_BURST(8), .ADDR_WIDTH(25), .ADDR_LIMIT(32)) dut (
    .rd_clk(clk), .reset(reset), .enable(enable), .rd_data_count(rd_data_count),
    .fifo_dout(fifo_dout), .fifo_dout_vd(fifo_dout_vd), .rd_fifo(rd_fifo), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_ack(wr_ack), .wr_data(wr_data), .wr_data_vd(wr_data_vd),
    .busy(busy), .burst_done(burst_done), .err(err)
  );

  always #5 clk = ~clk;

  // FIFO model: a pop requested in one cycle returns its word in the next
  always @(posedge clk) begin
    popped = rd_fifo;
    #1;
    if (popped && q.size() > 0) begin
      fifo_dout = q.pop_front();
      fifo_dout_vd = 1'b1;
    end else begin
      fifo_dout_vd = 1'b0;
    end
    rd_data_count = 10'(q.size());
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_burst(input logic [63:0] base);
    for (int i = 0; i < 8; i++) q.push_back(base + 64'(i));
    rd_data_count = 10'(q.size());
  endtask

  task automatic wait_req();
    int n = 0;
    while (!wr_req && n < 100) begin
      tick();
      n++;
    end
    chk("req_wait", {63'd0, wr_req}, 64'd1);
  endtask

  // ack in cycle t, then check cycles t+1..t+11 against the expected burst timeline
  task automatic run_burst(input logic [63:0] base, input logic [24:0] addr, input int drop_at);
    logic [24:0] nxt;
    nxt = (addr + 25'd8 >= 25'd32) ? 25'd0 : addr + 25'd8;
    wait_req();
    chk("req_addr", 64'(wr_addr), 64'(addr));
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      if (i == drop_at) enable = 1'b0;
      chk("rd_fifo", {63'd0, rd_fifo}, {63'd0, i <= 8});
      chk("wr_data_vd", {63'd0, wr_data_vd}, {63'd0, i >= 3 && i <= 10});
      if (i >= 3 && i <= 10) chk("wr_data", wr_data, base + 64'(i - 3));
      chk("burst_done", {63'd0, burst_done}, {63'd0, i == 11});
      if (i == 1) chk("req_drop", {63'd0, wr_req}, 64'd0);
      if (i == 11) begin
        chk("busy_end", {63'd0, busy}, 64'd0);
        chk("next_addr", 64'(wr_addr), 64'(nxt));
        chk("no_req_done", {63'd0, wr_req}, 64'd0);
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    vecs[0] = '{64'h100, 25'd0};
    vecs[1] = '{64'h200, 25'd8};
    vecs[2] = '{64'h300, 25'd16};
    vecs[3] = '{64'h400, 25'd24};
    vecs[4] = '{64'h500, 25'd0};
    tick();
    tick();
    chk("rst_rd_fifo", {63'd0, rd_fifo}, 64'd0);
    chk("rst_wr_req", {63'd0, wr_req}, 64'd0);
    chk("rst_addr", 64'(wr_addr), 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    reset = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 7; i++) q.push_back(64'h10 + 64'(i));
    rd_data_count = 10'(q.size());
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("thr_no_req", {63'd0, wr_req}, 64'd0);
    end
    q.push_back(64'h17);
    rd_data_count = 10'(q.size());
    tick();
    chk("thr_req", {63'd0, wr_req}, 64'd1);
    chk("thr_addr", 64'(wr_addr), 64'd0);
    run_burst(64'h10, 25'd0, 0);
    reset = 1'b1;
    #1;
    chk("rst_addr_clr", 64'(wr_addr), 64'd0);
    tick();
    reset = 1'b0;
    for (int v = 0; v < 5; v++) push_burst(vecs[v].base);
    for (int v = 0; v < 5; v++) run_burst(vecs[v].base, vecs[v].addr, 0);
    chk("wrap_err", {63'd0, err}, 64'd0);
    push_burst(64'h600);
    push_burst(64'h700);
    run_burst(64'h600, 25'd8, 4);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("drop_no_req", {63'd0, wr_req | busy}, 64'd0);
    end
    enable = 1'b1;
    wait_req();
    chk("rst_burst_addr", 64'(wr_addr), 64'd16);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_rd_fifo", {63'd0, rd_fifo}, 64'd1);
    chk("pre_rst_vd", {63'd0, wr_data_vd}, 64'd1);
    chk("pre_rst_data", wr_data, 64'h703);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rd_fifo", {63'd0, rd_fifo}, 64'd0);
    chk("async_vd", {63'd0, wr_data_vd}, 64'd0);
    chk("async_req", {63'd0, wr_req}, 64'd0);
    chk("async_busy", {63'd0, busy}, 64'd0);
    q.delete();
    rd_data_count = '0;
    tick();
    tick();
    reset = 1'b0;
    push_burst(64'h800);
    run_burst(64'h800, 25'd0, 0);
    tick();
    fifo_dout_vd = 1'b1;
    tick();
    chk("err_set", {63'd0, err}, 64'd1);
    push_burst(64'h900);
    run_burst(64'h900, 25'd8, 0);
    chk("err_sticky", {63'd0, err}, 64'd1);
    reset = 1'b1;
    #1;
    chk("err_clr", {63'd0, err}, 64'd0);
    tick();
    reset = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
